// File: rtl/avalon_mem_pkg.sv
// Shared types and constants for the Avalon-MM SRAM responder: FSM states,
// error read pattern and the stall LFSR seed/taps (x^16+x^14+x^13+x^11+1).
package avalon_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam logic [31:0] DEADBEEF  = 32'hDEAD_BEEF;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Shift-left Fibonacci form: bits 15,13,12,10 feed back into bit 0
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_feedback(input logic [15:0] state);
    return ^(state & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/stall_lfsr.sv
// 16-bit Fibonacci LFSR supplying the pseudo-random extra wait states;
// it steps only when the responder accepts a request.
module stall_lfsr
  import avalon_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [1:0] stall_bits
);

  logic [15:0] lfsr_r;

  // LFSR state: seeded on reset, one step per accepted request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_r <= LFSR_SEED;
    end else if (advance) begin
      lfsr_r <= {lfsr_r[14:0], lfsr_feedback(lfsr_r)};
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign stall_bits = lfsr_r[1:0];

endmodule

// File: rtl/avalon_sram_responder.sv
// Avalon-MM responder in front of a word-organised SRAM, with programmable and
// pseudo-random wait states, address/protocol error flagging and transfer counters.
module avalon_sram_responder
  import avalon_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_address,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  input  logic        stall_en,
  output logic        err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [15:0] err_count
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH);

  state_e         state_r, state_s;
  logic [4:0]     cnt_r, cnt_s;
  logic [31:0]    addr_r, wdata_r;
  logic           rd_r, wr_r;
  logic [31:0]    readdata_r;
  logic           waitreq_r, err_r;
  logic [15:0]    rd_count_r, wr_count_r, err_count_r;
  logic [31:0]    mem_r [DEPTH];

  logic           req_s, accept_s, abort_s, to_ack_s, bad_s, in_win_s;
  logic [31:0]    off_s;
  logic [AW-1:0]  idx_s;
  logic [1:0]     stall_s;

  stall_lfsr u_stall_lfsr (
    .clk        (clk),
    .reset      (reset),
    .advance    (accept_s),
    .stall_bits (stall_s)
  );

  // Decode of the latched command; a wrapped offset lands outside the window
  always_comb begin
    req_s    = avs_read | avs_write;
    off_s    = addr_r - BASE_ADDR;
    in_win_s = (off_s < WIN_BYTES);
    idx_s    = off_s[AW+1:2];
    bad_s    = (rd_r & wr_r) | ~in_win_s;
  end

  // Next-state logic and wait-state counter
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    abort_s  = 1'b0;
    to_ack_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          accept_s = 1'b1;
          state_s  = WAIT;
          cnt_s    = 5'(WAIT_CYCLES) + (stall_en ? {3'd0, stall_s} : 5'd0);
        end else begin
          state_s  = IDLE;
        end
      end
      WAIT: begin
        // Initiator withdrawing both strobes wins over a simultaneous completion
        if (!req_s) begin
          abort_s = 1'b1;
          state_s = IDLE;
        end else if (cnt_r == 5'd0) begin
          to_ack_s = 1'b1;
          state_s  = ACK;
        end else begin
          cnt_s = cnt_r - 5'd1;
        end
      end
      ACK:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state and command latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        addr_r  <= avs_address;
        wdata_r <= avs_writedata;
        rd_r    <= avs_read;
        wr_r    <= avs_write;
      end
    end
  end

  // Registered bus outputs, error pulse and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitreq_r   <= 1'b1;
      readdata_r  <= 32'd0;
      err_r       <= 1'b0;
      rd_count_r  <= 16'd0;
      wr_count_r  <= 16'd0;
      err_count_r <= 16'd0;
    end else begin
      waitreq_r <= (state_s != ACK);
      err_r     <= abort_s | (to_ack_s & bad_s);
      if (to_ack_s && rd_r) begin
        readdata_r <= bad_s ? DEADBEEF : mem_r[idx_s];
      end
      if ((abort_s || (to_ack_s && bad_s)) && (err_count_r != 16'hFFFF)) begin
        err_count_r <= err_count_r + 16'd1;
      end
      if (state_r == ACK && !bad_s && rd_r) begin
        rd_count_r <= rd_count_r + 16'd1;
      end
      if (state_r == ACK && !bad_s && wr_r) begin
        wr_count_r <= wr_count_r + 16'd1;
      end
    end
  end

  // SRAM array: contents survive reset, write commits as ACK closes
  always_ff @(posedge clk) begin
    if (state_r == ACK && wr_r && !bad_s) begin
      mem_r[idx_s] <= wdata_r;
    end
  end

  assign avs_readdata    = readdata_r;
  assign avs_waitrequest = waitreq_r;
  assign err             = err_r;
  assign rd_count        = rd_count_r;
  assign wr_count        = wr_count_r;
  assign err_count       = err_count_r;

endmodule

// File: tb/tb_avalon_sram_responder.sv
// Directed bench for avalon_sram_responder: latency, data, window/protocol errors,
// abort, random stalls with a word scoreboard, reset mid-transfer and a block copy.
module tb_avalon_sram_responder;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 1024;
  localparam int          W     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        avs_read, avs_write, stall_en;
  logic [31:0] avs_address, avs_writedata, avs_readdata;
  logic        avs_waitrequest, err;
  logic [15:0] rd_count, wr_count, err_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [16];
  logic [31:0] rdata;
  int          waits;
  logic        e;
  int          exp_rd, exp_wr;

  always #5 clk = ~clk;

  avalon_sram_responder #(
    .BASE_ADDR   (BASE),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_address     (avs_address),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest),
    .stall_en        (stall_en),
    .err             (err),
    .rd_count        (rd_count),
    .wr_count        (wr_count),
    .err_count       (err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus transfer; waits counts negedges with waitrequest high, the IDLE sampling
  // cycle included, so a transfer without stall reports W+2. Address and data are
  // scrambled mid-wait to confirm the responder uses its latched copies.
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd_o, output int waits_o, output logic err_o);
    bit done = 1'b0;
    waits_o = 0;
    rd_o    = 32'd0;
    err_o   = 1'b0;
    @(negedge clk);
    avs_read = rd; avs_write = wr; avs_address = addr; avs_writedata = wd;
    for (int n = 0; n < 40 && !done; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 2) begin
        avs_address   = addr ^ 32'h0000_0040;
        avs_writedata = ~wd;
      end
      if (avs_waitrequest) waits_o++;
      else begin
        done  = 1'b1;
        rd_o  = avs_readdata;
        err_o = err;
      end
    end
    check("xfer_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; avs_read = 1'b0; avs_write = 1'b0; stall_en = 1'b0;
    avs_address = 32'd0; avs_writedata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_waitreq", {31'd0, avs_waitrequest}, 32'd1);
    check("rst_rdata", avs_readdata, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_counts", {rd_count, wr_count}, 32'd0);
    check("rst_errcnt", {16'd0, err_count}, 32'd0);
    reset = 1'b0;

    // Basic write then read with fixed waits only
    xfer(1'b0, 1'b1, BASE + 32'h10, 32'h1234_5678, rdata, waits, e);
    check("wr_lat", waits, W + 2);
    check("wr_err", {31'd0, e}, 32'd0);
    xfer(1'b1, 1'b0, BASE + 32'h10, 32'd0, rdata, waits, e);
    check("rd_lat", waits, W + 2);
    check("rd_data", rdata, 32'h1234_5678);
    check("rd_wr_cnt", {rd_count, wr_count}, {16'd1, 16'd1});

    // Window edges
    xfer(1'b0, 1'b1, BASE, 32'hA5A5_0000, rdata, waits, e);
    xfer(1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'd0, rdata, waits, e);
    check("oow_rd_data", rdata, 32'hDEAD_BEEF);
    check("oow_rd_err", {31'd0, e}, 32'd1);
    check("oow_rd_cnt", {err_count, rd_count}, {16'd1, 16'd1});
    xfer(1'b0, 1'b1, BASE + 32'(4 * DEPTH), 32'h1111_1111, rdata, waits, e);
    check("oow_wr_err", {31'd0, e}, 32'd1);
    check("oow_wr_cnt", {err_count, wr_count}, {16'd2, 16'd2});
    xfer(1'b1, 1'b0, BASE - 32'd4, 32'd0, rdata, waits, e);
    check("below_base", {16'd0, err_count}, 32'd3);
    xfer(1'b1, 1'b0, BASE, 32'd0, rdata, waits, e);
    check("word0_intact", rdata, 32'hA5A5_0000);

    // Read and write together is a protocol error
    xfer(1'b1, 1'b1, BASE, 32'hFFFF_FFFF, rdata, waits, e);
    check("proto_data", rdata, 32'hDEAD_BEEF);
    check("proto_err", {31'd0, e}, 32'd1);
    check("proto_cnt", {err_count, wr_count}, {16'd4, 16'd2});
    xfer(1'b1, 1'b0, BASE, 32'd0, rdata, waits, e);
    check("proto_nowrite", rdata, 32'hA5A5_0000);

    // Abort: strobes dropped while waiting
    @(negedge clk);
    avs_read = 1'b1; avs_address = BASE;
    @(negedge clk);
    avs_read = 1'b0;
    @(negedge clk);
    check("abort_err", {31'd0, err}, 32'd1);
    check("abort_cnt", {16'd0, err_count}, 32'd5);
    check("abort_idle", {31'd0, avs_waitrequest}, 32'd1);

    // Random stalls over a 16-word scoreboard
    exp_rd = 3; exp_wr = 2;
    stall_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      xfer(1'b0, 1'b1, BASE + 32'(4 * i), model[i], rdata, waits, e);
      check("stall_lat", {31'd0, (waits >= W + 2) && (waits <= W + 5)}, 32'd1);
      exp_wr++;
    end
    for (int i = 0; i < 200; i++) begin
      int idx = $urandom_range(15);
      if ($urandom_range(1) == 1) begin
        model[idx] = $urandom;
        xfer(1'b0, 1'b1, BASE + 32'(4 * idx), model[idx], rdata, waits, e);
        exp_wr++;
      end else begin
        xfer(1'b1, 1'b0, BASE + 32'(4 * idx), 32'd0, rdata, waits, e);
        check("sb_data", rdata, model[idx]);
        exp_rd++;
      end
      check("stall_lat", {31'd0, (waits >= W + 2) && (waits <= W + 5)}, 32'd1);
      check("stall_err", {31'd0, e}, 32'd0);
    end
    check("stall_cnt", {rd_count, wr_count}, {16'(exp_rd), 16'(exp_wr)});
    stall_en = 1'b0;

    // Source blocks for the copy, then reset during a pending write
    for (int i = 0; i < 8; i++) xfer(1'b0, 1'b1, BASE + 32'(4 * (32 + i)), 32'hC0DE_0000 + 32'(i), rdata, waits, e);
    @(negedge clk);
    avs_write = 1'b1; avs_address = BASE + 32'h10; avs_writedata = 32'hCAFE_F00D;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_waitreq", {31'd0, avs_waitrequest}, 32'd1);
    check("midrst_rdata", avs_readdata, 32'd0);
    @(negedge clk);
    avs_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_cnt", {rd_count, wr_count}, 32'd0);

    // Accelerator-style copy: 4 blocks of 2 words, read src then write dest
    for (int i = 0; i < 8; i++) begin
      xfer(1'b1, 1'b0, BASE + 32'(4 * (32 + i)), 32'd0, rdata, waits, e);
      xfer(1'b0, 1'b1, BASE + 32'(4 * (64 + i)), rdata, rdata, waits, e);
    end
    check("copy_cnt", {rd_count, wr_count}, {16'd8, 16'd8});
    check("copy_errcnt", {16'd0, err_count}, 32'd0);
    xfer(1'b1, 1'b0, BASE + 32'h10, 32'd0, rdata, waits, e);
    check("midrst_word", rdata, model[4]);
    for (int i = 0; i < 8; i += 3) begin
      xfer(1'b1, 1'b0, BASE + 32'(4 * (64 + i)), 32'd0, rdata, waits, e);
      check("copy_data", rdata, 32'hC0DE_0000 + 32'(i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
